// File: rtl/seq_det_evt_fifo.sv
// Event timestamp FIFO behind a serial sequence detector: stamps each detection
// with a free-running counter, queues the stamps and keeps event/drop statistics.
module seq_det_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    det_in,
    input  logic                    clr,
    output logic [TS_W-1:0]         ts_data,
    output logic                    ts_valid,
    input  logic                    ts_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic [TS_W-1:0]         evt_cnt,
    output logic [TS_W-1:0]         drop_cnt,
    output logic                    ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = AW + 1;

    logic [TS_W-1:0] tcnt_reg;
    logic [TS_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   rd_ptr_next;
    logic [LW-1:0]   level_reg;
    logic [LW-1:0]   level_next;
    logic [TS_W-1:0] head_reg;
    logic [TS_W-1:0] head_next;
    logic [TS_W-1:0] evt_cnt_reg;
    logic [TS_W-1:0] drop_cnt_reg;
    logic            ovf_reg;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign ts_valid = (level_reg != '0);
    assign ts_data  = head_reg;
    assign level    = level_reg;
    assign evt_cnt  = evt_cnt_reg;
    assign drop_cnt = drop_cnt_reg;
    assign ovf      = ovf_reg;

    always_comb begin
        full        = (level_reg == LW'(DEPTH));
        pop         = ts_valid & ts_ready;
        push        = det_in & (~full | pop);
        drop        = det_in & full & ~pop;
        rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        level_next  = level_reg + LW'(push) - LW'(pop);
        // Head register is the registered read port; bypass the incoming stamp
        // when it becomes the only entry so push latency stays at one cycle.
        head_next   = '0;
        if (level_next != '0) begin
            if (push && (wr_ptr_reg == rd_ptr_next)) begin
                head_next = tcnt_reg;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clr && push) begin
            mem[wr_ptr_reg] <= tcnt_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_reg     <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            head_reg     <= '0;
            evt_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            tcnt_reg <= tcnt_reg + TS_W'(1);
            if (clr) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                level_reg    <= '0;
                head_reg     <= '0;
                evt_cnt_reg  <= '0;
                drop_cnt_reg <= '0;
                ovf_reg      <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                rd_ptr_reg <= rd_ptr_next;
                level_reg  <= level_next;
                head_reg   <= head_next;
                if (det_in) begin
                    evt_cnt_reg <= evt_cnt_reg + TS_W'(1);
                end
                if (drop) begin
                    ovf_reg <= 1'b1;
                    if (drop_cnt_reg != '1) begin
                        drop_cnt_reg <= drop_cnt_reg + TS_W'(1);
                    end
                end
            end
        end
    end

endmodule
